// File: rtl/pp_tx_pkg.sv
// Shared sizing helpers and configuration checks for the periplex TX serializer.
package pp_tx_pkg;

    // Number of output beats needed to carry one packet.
    function automatic int beats_f(input int data_width, input int beat_width);
        return data_width / beat_width;
    endfunction

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int cnt_w_f(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    // FIFO pointer width; pointers wrap naturally because depth is a power of two.
    function automatic int ptr_w_f(input int depth);
        return cnt_w_f(depth);
    endfunction

    // FIFO occupancy width; one extra bit so that a full FIFO is representable.
    function automatic int lvl_w_f(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // Even parity of a beat, kept for link-side protection logic.
    function automatic logic parity16_f(input logic [15:0] beat);
        return ^beat;
    endfunction

    // Legal configuration: packet splits into whole beats, depth is a power of two >= 2.
    function automatic bit cfg_ok_f(input int data_width, input int beat_width, input int depth);
        return (beat_width > 32'sd0) &&
               ((data_width % beat_width) == 32'sd0) &&
               (depth >= 32'sd2) &&
               ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/pp_sync_fifo.sv
// Single-clock register-array FIFO. A push into a full FIFO is accepted when
// a pop happens on the same edge, so a streaming consumer never forces a drop.
module pp_sync_fifo
    import pp_tx_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int PW = ptr_w_f(DEPTH),
    localparam int LW = lvl_w_f(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             push_ok,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic [LW-1:0]    level_next
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic [LW-1:0]    level_next_s;

    assign full_s    = (level_r == LW'(DEPTH));
    assign pop_ok_s  = pop && (level_r != {LW{1'b0}});
    assign push_ok_s = push && (!full_s || pop_ok_s);

    // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_comb begin
        level_next_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_next_s = level_r + LW'(1'b1);
            2'b01:   level_next_s = level_r - LW'(1'b1);
            default: level_next_s = level_r;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            level_r <= level_next_s;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign push_ok    = push_ok_s;
    assign head       = mem_r[rd_ptr_r];
    assign level      = level_r;
    assign level_next = level_next_s;

endmodule

// File: rtl/pp_tx_serializer.sv
// Buffers encoder packets and streams each one out as MSB-first beats on a
// valid/ready link. The encoder cannot be stalled, so the block reports an
// almost-full warning and a sticky overflow flag for packets it had to drop.
module pp_tx_serializer
    import pp_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 48,
    parameter int BEAT_WIDTH   = 16,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_en,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_afull,
    output logic                   out_valid,
    output logic [BEAT_WIDTH-1:0]  out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int BEATS = beats_f(DATA_WIDTH, BEAT_WIDTH);
    localparam int BCW   = cnt_w_f(BEATS);
    localparam int LW    = lvl_w_f(DEPTH);

    if (!cfg_ok_f(DATA_WIDTH, BEAT_WIDTH, DEPTH)) begin : g_cfg_err
        $error("pp_tx_serializer: DATA_WIDTH must be a multiple of BEAT_WIDTH and DEPTH a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] head_s;
    logic [LW-1:0]         level_s;
    logic [LW-1:0]         level_next_s;
    logic                  push_ok_s;
    logic                  valid_s;
    logic                  last_beat_s;
    logic                  xfer_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [BEAT_WIDTH-1:0] beat_s;
    logic [BCW-1:0]        bcnt_r;
    logic                  in_afull_r;
    logic                  ovf_r;

    pp_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (in_en),
        .push_data  (in_data),
        .pop        (pop_s),
        .push_ok    (push_ok_s),
        .head       (head_s),
        .level      (level_s),
        .level_next (level_next_s)
    );

    assign valid_s     = (level_s != {LW{1'b0}});
    assign last_beat_s = (bcnt_r == BCW'(BEATS - 1));
    assign xfer_s      = valid_s && out_ready;
    assign pop_s       = xfer_s && last_beat_s;
    assign drop_s      = in_en && !push_ok_s;

    // Select the current beat of the head packet, most significant beat first.
    always_comb begin
        beat_s = BEAT_WIDTH'(head_s >> ((BEATS - 1 - int'(bcnt_r)) * BEAT_WIDTH));
    end

    // Beat counter: advance on each accepted beat, wrap to zero when the packet completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_r <= {BCW{1'b0}};
        end else if (xfer_s) begin
            if (last_beat_s) begin
                bcnt_r <= {BCW{1'b0}};
            end else begin
                bcnt_r <= bcnt_r + BCW'(1'b1);
            end
        end else begin
            bcnt_r <= bcnt_r;
        end
    end

    // Almost-full is registered from the occupancy the FIFO is about to have.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_afull_r <= 1'b0;
        end else begin
            in_afull_r <= ((DEPTH - int'(level_next_s)) <= AFULL_MARGIN);
        end
    end

    // Sticky overflow: a drop sets it and takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign out_valid = valid_s;
    assign out_data  = valid_s ? beat_s : {BEAT_WIDTH{1'b0}};
    assign out_last  = valid_s && last_beat_s;
    assign in_afull  = in_afull_r;
    assign level     = level_s;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pp_tx_serializer.sv
// Self-checking bench for pp_tx_serializer: a packet table drives the main
// traffic, a cycle model with a beat scoreboard checks every output on the
// falling edge, and short hand-written sequences cover the corner cases.
module tb_pp_tx_serializer;

    localparam int DEPTH = 8;
    localparam int AM    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_en;
    logic [47:0] in_data;
    logic        in_afull;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic [3:0]  level;
    logic        ovf;
    logic        ovf_clr;

    pp_tx_serializer #(
        .DATA_WIDTH   (48),
        .BEAT_WIDTH   (16),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_en     (in_en),
        .in_data   (in_data),
        .in_afull  (in_afull),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [47:0] din;
        logic [15:0] b0;
        logic [15:0] b1;
        logic [15:0] b2;
    } vec_t;

    vec_t        vecs [8];
    beat_t       sbq [$];
    logic [15:0] cur_exp [3];
    int          mlev;
    logic        movf;
    logic        mafull;
    int          checks;
    int          errors;
    logic        saw_afull;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model and scoreboard: check current outputs, then predict the next edge.
    always @(negedge clk) begin
        logic pop_m;
        logic push_m;
        logic drop_m;
        int   nlev;
        if (!rst_n) begin
            sbq.delete();
            mlev   = 0;
            movf   = 1'b0;
            mafull = 1'b0;
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_data",  64'(out_data),  64'd0);
            chk("rst_last",  64'(out_last),  64'd0);
            chk("rst_level", 64'(level),     64'd0);
            chk("rst_ovf",   64'(ovf),       64'd0);
            chk("rst_afull", 64'(in_afull),  64'd0);
        end else begin
            chk("level", 64'(level),     64'(mlev));
            chk("valid", 64'(out_valid), 64'(mlev != 0));
            chk("ovf",   64'(ovf),       64'(movf));
            chk("afull", 64'(in_afull),  64'(mafull));
            pop_m = 1'b0;
            if (mlev != 0 && sbq.size() > 0) begin
                chk("beat_data", 64'(out_data), 64'(sbq[0].data));
                chk("beat_last", 64'(out_last), 64'(sbq[0].last));
                if (out_ready) begin
                    pop_m = sbq[0].last;
                    void'(sbq.pop_front());
                end
            end else if (mlev != 0) begin
                chk("sb_underrun", 64'd1, 64'd0);
            end
            push_m = in_en && (mlev < DEPTH || pop_m);
            drop_m = in_en && !push_m;
            if (push_m) begin
                for (int i = 0; i < 3; i++) begin
                    sbq.push_back('{data: cur_exp[i], last: (i == 2)});
                end
            end
            nlev   = mlev + int'(push_m) - int'(pop_m);
            mafull = ((DEPTH - nlev) <= AM);
            movf   = drop_m ? 1'b1 : (ovf_clr ? 1'b0 : movf);
            mlev   = nlev;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_pkt(input logic [47:0] d, input logic [15:0] e0,
                             input logic [15:0] e1, input logic [15:0] e2);
        in_en      = 1'b1;
        in_data    = d;
        cur_exp[0] = e0;
        cur_exp[1] = e1;
        cur_exp[2] = e2;
    endtask

    task automatic drive_vec(input int i);
        drive_pkt(vecs[i].din, vecs[i].b0, vecs[i].b1, vecs[i].b2);
    endtask

    task automatic drain();
        in_en     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && mlev != 0; i++) begin
            tick();
        end
        chk("drain_timeout", 64'(mlev != 0), 64'd0);
    endtask

    initial begin
        vecs[0] = '{48'hAAAA_BBBB_CCCC, 16'hAAAA, 16'hBBBB, 16'hCCCC};
        vecs[1] = '{48'h1234_5678_9ABC, 16'h1234, 16'h5678, 16'h9ABC};
        vecs[2] = '{48'hFFFF_0000_FFFF, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[3] = '{48'h0000_0000_0001, 16'h0000, 16'h0000, 16'h0001};
        vecs[4] = '{48'h8000_0000_0000, 16'h8000, 16'h0000, 16'h0000};
        vecs[5] = '{48'hDEAD_BEEF_CAFE, 16'hDEAD, 16'hBEEF, 16'hCAFE};
        vecs[6] = '{48'h0F0F_F0F0_5A5A, 16'h0F0F, 16'hF0F0, 16'h5A5A};
        vecs[7] = '{48'h7777_8888_9999, 16'h7777, 16'h8888, 16'h9999};

        checks     = 0;
        errors     = 0;
        mlev       = 0;
        movf       = 1'b0;
        mafull     = 1'b0;
        saw_afull  = 1'b0;
        rst_n      = 1'b0;
        in_en      = 1'b0;
        in_data    = 48'h0;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
        cur_exp[0] = 16'h0;
        cur_exp[1] = 16'h0;
        cur_exp[2] = 16'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single packet: one-cycle latency, MSB beat first, then drain.
        out_ready = 1'b1;
        drive_vec(0);
        tick();
        in_en = 1'b0;
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("first_beat",    64'(out_data),  64'h0000_0000_0000_AAAA);
        drain();

        // Stall after the first beat: second beat must hold for five cycles.
        out_ready = 1'b1;
        drive_vec(1);
        tick();
        in_en = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data",  64'(out_data),  64'h0000_0000_0000_5678);
            chk("stall_valid", 64'(out_valid), 64'd1);
        end
        drain();

        // Back-to-back: the whole table on consecutive cycles with ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_vec(i);
            tick();
            if (in_afull) saw_afull = 1'b1;
        end
        in_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (in_afull) saw_afull = 1'b1;
        end
        chk("b2b_afull_seen", 64'(saw_afull), 64'd1);
        drain();

        // Overflow: fill with ready low, drop the ninth, then clear interplay.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_vec(i % 8);
            if (i == 8) drive_pkt(48'h9999_9999_9999, 16'h9999, 16'h9999, 16'h9999);
            tick();
        end
        in_en = 1'b0;
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_set",   64'(ovf),   64'd1);
        drive_pkt(48'h5555_5555_5555, 16'h5555, 16'h5555, 16'h5555);
        ovf_clr = 1'b1;
        tick();
        in_en   = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_set_wins", 64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);
        drain();

        // Full FIFO with a push on the same edge as the head pop.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_vec(7 - i);
            tick();
        end
        in_en     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !(sbq.size() > 0 && sbq[0].last); i++) begin
            tick();
        end
        drive_pkt(48'h3C3C_4B4B_5A5A, 16'h3C3C, 16'h4B4B, 16'h5A5A);
        tick();
        in_en = 1'b0;
        out_ready = 1'b0;
        chk("fullpop_level", 64'(level), 64'd8);
        chk("fullpop_ovf",   64'(ovf),   64'd0);
        drain();

        // Reset in the middle of a packet discards it completely.
        out_ready = 1'b1;
        drive_vec(5);
        tick();
        in_en = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data",  64'(out_data),  64'd0);
        chk("midrst_level", 64'(level),     64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        drive_vec(6);
        tick();
        in_en = 1'b0;
        chk("post_rst_beat", 64'(out_data), 64'h0000_0000_0000_0F0F);
        drain();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_tx_serializer.md
Name: pp_tx_serializer

Overview:
- Sits directly downstream of the periplex encoder output (fifo_en / 48-bit fifo_data) and feeds the host-bound link.
- Buffers encoder response packets in a small synchronous FIFO and splits each packet into BEAT_WIDTH beats, MSB first, on a valid/ready stream.
- The encoder has no backpressure input. The block therefore exports an almost-full flag for throttling and a sticky overflow flag for dropped packets.

Parameters:
- DATA_WIDTH, 48, packet width from the encoder (equals RD_DATA_BUS_WIDTH).
- BEAT_WIDTH, 16, output beat width; DATA_WIDTH must be an integer multiple; BEATS = DATA_WIDTH/BEAT_WIDTH.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AFULL_MARGIN, 2, in_afull asserts when free entries <= AFULL_MARGIN.

Ports:
- clk  in  1  periplex clock (pp_clk domain).
- rst_n  in  1  asynchronous active-low reset.
- in_en  in  1  packet write strobe from the encoder (fifo_en).
- in_data  in  DATA_WIDTH  packet from the encoder (fifo_data).
- in_afull  out  1  almost-full, registered.
- out_valid  out  1  beat valid.
- out_data  out  BEAT_WIDTH  beat payload.
- out_last  out  1  final beat of the current packet.
- out_ready  in  1  downstream accept.
- level  out  clog2(DEPTH)+1  stored packet count, registered.
- ovf  out  1  sticky overflow.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, beat counter=0, out_valid=0, out_last=0, out_data=0, in_afull=0, ovf=0. Reset mid-packet discards all stored packets and any partially sent packet; no beat is emitted after reset until a new in_en.
- Write: in_en=1 is accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle. Accepted data is stored at the write pointer; pointers wrap modulo DEPTH.
- Drop: in_en=1 with level==DEPTH and no same-cycle pop drops the packet, leaves FIFO contents unchanged, and sets ovf=1 on the next edge.
- ovf handling: ovf holds until ovf_clr=1. A simultaneous drop and ovf_clr leaves ovf=1 (set wins).
- Beat counter bcnt ranges 0..BEATS-1 and indexes the head entry.
- out_data = head[DATA_WIDTH-1-bcnt*BEAT_WIDTH -: BEAT_WIDTH], i.e. MSB beat first.
- out_valid = (level!=0); out_last = out_valid && (bcnt==BEATS-1).
- out_data and out_last are driven from registered state only and depend on no input combinationally.
- Transfer occurs when out_valid && out_ready.
  - Transfer on a non-last beat: bcnt increments.
  - Transfer on the last beat: bcnt returns to 0 and the head is popped.
- Stability: while out_valid=1 and out_ready=0, out_data, out_last and bcnt hold.
- Latency: a packet written at edge N into an empty FIFO gives out_valid=1 in the cycle after edge N (one cycle). First beat is out_data=in_data[47:32].
- Throughput: one beat per cycle with out_ready held high; back-to-back packets produce no bubble between the last beat of one and the first beat of the next.
- Level update: level += (write accepted) - (pop), computed on the same edge. A simultaneous write and pop leaves level unchanged.
- in_afull is registered from the next-state level: asserted iff DEPTH - level_next <= AFULL_MARGIN.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package pp_tx_pkg holds:
  - BEATS and the pointer/level width functions;
  - a compile-time check that DATA_WIDTH % BEAT_WIDTH == 0 and that DEPTH is a power of two.
- One natural sub-module: pp_sync_fifo, a single-clock register-array FIFO with push, pop, head data, level, and same-cycle push-when-full-with-pop support.
- Beat sequencing, overflow and almost-full logic stay in pp_tx_serializer.

Test Plan:
- Single packet: in_data=48'hAAAA_BBBB_CCCC, out_ready=1 -> beats 16'hAAAA, 16'hBBBB, 16'hCCCC on three consecutive cycles; out_last only on 16'hCCCC; level returns 1->0.
- Stall: out_ready low after the first beat for 5 cycles -> out_data holds 16'hBBBB with out_valid=1, then resumes; no beat lost or repeated.
- Back-to-back: 8 packets, with in_en on consecutive cycles and out_ready=1 -> 24 beats, no idle cycles; in_afull asserts when level reaches 6 (DEPTH=8, margin 2).
- Overflow: out_ready=0, write 9 packets -> level=8; ninth packet dropped and ovf=1. Draining then gives the first 8 packets in order. ovf_clr clears ovf; ovf_clr coincident with a new drop keeps ovf=1.
- Full with simultaneous pop: level=8, in_en on the cycle the last beat of the head is accepted -> write accepted, level stays 8, ovf stays 0.
- Reset mid-packet: rst_n low after beat 1 of 3 -> all outputs zero immediately; after release, out_valid stays 0 until the next in_en.
